// File: rtl/pht_port_arbiter.sv
// Shares one single-port PHT RAM between fetch lookups and buffered counter updates (3-cycle RMW),
// and writes Weakly_taken into every entry after reset. Define PHT_ARB_PERF_EN to add perf counters.
module pht_port_arbiter #(
    parameter int INDEX_W      = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lookup_valid,
    input  logic [INDEX_W-1:0] lookup_index,
    output logic               lookup_stall,
    output logic               lookup_rvalid,
    output logic               pred_take,
    input  logic               upd_valid,
    input  logic [INDEX_W-1:0] upd_index,
    input  logic               upd_taken,
    output logic               upd_drop,
    output logic               init_done,
    output logic               ram_en,
    output logic               ram_we,
    output logic [INDEX_W-1:0] ram_addr,
    output logic [1:0]         ram_wdata,
    input  logic [1:0]         ram_rdata
`ifdef PHT_ARB_PERF_EN
    ,
    output logic [31:0]        perf_lookups,
    output logic [31:0]        perf_updates,
    output logic [31:0]        perf_drops,
    output logic [31:0]        perf_stall_cycles
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0]   FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [SC_W-1:0]    STARVE_MAX    = SC_W'(STARVE_LIMIT);
    localparam logic [INDEX_W-1:0] INIT_LAST     = {INDEX_W{1'b1}};

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_UPD_RD = 2'd2;
    localparam logic [1:0] ST_UPD_WR = 2'd3;

    logic [1:0]         state;
    logic [INDEX_W-1:0] init_cnt;
    logic [INDEX_W-1:0] fifo_index [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_taken;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [SC_W-1:0]    starve_cnt;
    logic [1:0]         upd_wdata;
    logic               rvalid_q;
    logic               pred_q;

    logic               fifo_empty;
    logic               fifo_full;
    logic [INDEX_W-1:0] head_index;
    logic               head_taken;
    logic               in_idle;
    logic               upd_sel;
    logic               lookup_acc;
    logic               push;
    logic               pop;

    // Saturating 2-bit counter in the encoding 00 SNT, 01 WNT, 11 WT, 10 ST.
    function automatic logic [1:0] next_ctr(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        case (cur)
            2'b00:   nxt = taken ? 2'b01 : 2'b00;
            2'b01:   nxt = taken ? 2'b11 : 2'b00;
            2'b11:   nxt = taken ? 2'b10 : 2'b01;
            default: nxt = taken ? 2'b10 : 2'b11;
        endcase
        return nxt;
    endfunction

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
    assign head_index = fifo_index[rd_ptr];
    assign head_taken = fifo_taken[rd_ptr];

    assign in_idle    = rst && (state == ST_IDLE);
    assign upd_sel    = in_idle && !fifo_empty && (!lookup_valid || (starve_cnt == STARVE_MAX));
    assign lookup_acc = in_idle && lookup_valid && !upd_sel;

    // Fullness is judged at the start of the cycle, so a same-cycle pop never frees a slot.
    assign push     = rst && upd_valid && !fifo_full;
    assign pop      = rst && (state == ST_UPD_WR);
    assign upd_drop = rst && upd_valid && fifo_full;

    assign lookup_stall  = !in_idle || upd_sel;
    assign lookup_rvalid = rvalid_q;
    assign pred_take     = rvalid_q ? ram_rdata[1] : pred_q;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = 2'b00;
        if (rst) begin
            case (state)
                ST_INIT: begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = init_cnt;
                    ram_wdata = 2'b11;
                end
                ST_IDLE: begin
                    if (upd_sel) begin
                        ram_en   = 1'b1;
                        ram_addr = head_index;
                    end else if (lookup_valid) begin
                        ram_en   = 1'b1;
                        ram_addr = lookup_index;
                    end
                end
                ST_UPD_WR: begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = head_index;
                    ram_wdata = upd_wdata;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_INIT;
            init_cnt   <= '0;
            init_done  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            starve_cnt <= '0;
            upd_wdata  <= 2'b00;
            rvalid_q   <= 1'b0;
            pred_q     <= 1'b0;
        end else begin
            rvalid_q <= lookup_acc;
            if (rvalid_q) begin
                pred_q <= ram_rdata[1];
            end

            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + INDEX_W'(1);
                    if (init_cnt == INIT_LAST) begin
                        state     <= ST_IDLE;
                        init_done <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (upd_sel) begin
                        starve_cnt <= '0;
                        state      <= ST_UPD_RD;
                    end else if (lookup_acc && !fifo_empty && (starve_cnt != STARVE_MAX)) begin
                        starve_cnt <= starve_cnt + SC_W'(1);
                    end
                end
                ST_UPD_RD: begin
                    upd_wdata <= next_ctr(ram_rdata, head_taken);
                    state     <= ST_UPD_WR;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_index[wr_ptr] <= upd_index;
            fifo_taken[wr_ptr] <= upd_taken;
        end
    end

`ifdef PHT_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_lookups      <= '0;
            perf_updates      <= '0;
            perf_drops        <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (lookup_acc && (perf_lookups != '1)) begin
                perf_lookups <= perf_lookups + 32'd1;
            end
            if (pop && (perf_updates != '1)) begin
                perf_updates <= perf_updates + 32'd1;
            end
            if (upd_drop && (perf_drops != '1)) begin
                perf_drops <= perf_drops + 32'd1;
            end
            if (lookup_valid && lookup_stall && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
